// File: rtl/mux_scan_sel.sv
// N-channel selector with a registered output and an auto-scan mode.
// The selected channel index drives data_out one clock later.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_MANUAL | cur_sel follows sel_in; dwell counter held at 0
// ST_SCAN   | channels visited in turn, each held DWELL cycles
// ST_PAUSE  | scan position and dwell count frozen while hold=1
module mux_scan_sel #(
  parameter int N_IN  = 7,
  parameter int WIDTH = 1,
  parameter int SEL_W = 3,
  parameter int DWELL = 4
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [N_IN*WIDTH-1:0]   data_in,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel_in,
  input  logic                    hold,
  output logic [WIDTH-1:0]        data_out,
  output logic [SEL_W-1:0]        cur_sel,
  output logic                    sel_valid,
  output logic                    wrap
);

  localparam int                CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(N_IN - 1);

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_SCAN   = 2'd1,
    ST_PAUSE  = 2'd2
  } state_t;

  state_t             r_state;
  logic [SEL_W-1:0]   r_cur_sel;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_data_out;
  logic               r_sel_valid;
  logic               r_wrap;

  logic [WIDTH-1:0]   w_chan;
  logic               w_in_range;

  // Unmatched (out-of-range) indices fall through to zero.
  always_comb begin
    w_chan = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (int'(r_cur_sel) == k) w_chan = data_in[k*WIDTH +: WIDTH];
    end
  end

  assign w_in_range = (int'(r_cur_sel) < N_IN);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_MANUAL;
      r_cur_sel   <= '0;
      r_cnt       <= '0;
      r_data_out  <= '0;
      r_sel_valid <= 1'b0;
      r_wrap      <= 1'b0;
    end else begin
      r_wrap      <= 1'b0;
      r_data_out  <= w_chan;
      r_sel_valid <= w_in_range;
      case (r_state)
        ST_MANUAL: begin
          r_cnt <= '0;
          if (mode) begin
            r_state   <= ST_SCAN;
            r_cur_sel <= '0;
          end else begin
            r_cur_sel <= sel_in;
          end
        end
        ST_SCAN, ST_PAUSE: begin
          if (!mode) begin
            r_state   <= ST_MANUAL;
            r_cur_sel <= sel_in;
            r_cnt     <= '0;
          end else if (hold) begin
            r_state <= ST_PAUSE;
          end else begin
            // Leaving PAUSE counts on the same edge, so resume is seamless.
            r_state <= ST_SCAN;
            if (r_cnt == CNT_LAST) begin
              r_cnt <= '0;
              if (r_cur_sel == SEL_LAST) begin
                r_cur_sel <= '0;
                r_wrap    <= 1'b1;
              end else begin
                r_cur_sel <= r_cur_sel + SEL_W'(1);
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          r_state   <= ST_MANUAL;
          r_cur_sel <= '0;
          r_cnt     <= '0;
        end
      endcase
    end
  end

  assign data_out  = r_data_out;
  assign cur_sel   = r_cur_sel;
  assign sel_valid = r_sel_valid;
  assign wrap      = r_wrap;

endmodule

// File: tb/tb_mux_scan_sel.sv
// Directed bench for mux_scan_sel: reset, manual sweep, scan/pause/priority,
// async reset mid-scan, plus a DWELL=1 instance for every-edge advance.
module tb_mux_scan_sel;

  logic         clock;
  logic         resetn;
  logic [6:0]   data_in;
  logic         mode;
  logic [2:0]   sel_in;
  logic         hold;

  logic         dout, valid, wrap;
  logic [2:0]   csel;
  logic         d1_dout, d1_valid, d1_wrap;
  logic [2:0]   d1_csel;

  int total = 0;
  int bad   = 0;

  mux_scan_sel #(.N_IN(7), .WIDTH(1), .SEL_W(3), .DWELL(4)) dut (
    .clock(clock), .resetn(resetn), .data_in(data_in), .mode(mode),
    .sel_in(sel_in), .hold(hold), .data_out(dout), .cur_sel(csel),
    .sel_valid(valid), .wrap(wrap)
  );

  mux_scan_sel #(.N_IN(7), .WIDTH(1), .SEL_W(3), .DWELL(1)) dut_d1 (
    .clock(clock), .resetn(resetn), .data_in(data_in), .mode(mode),
    .sel_in(sel_in), .hold(hold), .data_out(d1_dout), .cur_sel(d1_csel),
    .sel_valid(d1_valid), .wrap(d1_wrap)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] pat;
    int         exp_sel;
    int         prev_sel;

    resetn  = 1'b0;
    data_in = 7'h7F;
    mode    = 1'b0;
    sel_in  = 3'd3;
    hold    = 1'b0;

    // Reset held with clock running
    repeat (3) tick();
    chk("rst_dout",  dout,  0);
    chk("rst_valid", valid, 0);
    chk("rst_csel",  csel,  0);
    chk("rst_wrap",  wrap,  0);

    resetn = 1'b1;
    tick();
    chk("rel_csel",  csel,  3);
    chk("rel_dout",  dout,  1);
    chk("rel_valid", valid, 1);

    // Manual sweep; index 7 is out of range
    data_in = 7'b1010110;
    pat     = 8'b0101_0110;
    for (int s = 0; s < 8; s++) begin
      sel_in = 3'(s);
      tick();
      chk("man_csel", csel, s);
      tick();
      chk("man_dout",  dout,  pat[s]);
      chk("man_valid", valid, (s < 7) ? 1 : 0);
      chk("man_wrap",  wrap,  0);
    end
    sel_in = 3'd0;
    tick();

    // Scan, DWELL=4: two full wraps (56 edges)
    mode = 1'b1;
    tick();
    chk("scan_start", csel, 0);
    for (int i = 1; i <= 56; i++) begin
      tick();
      exp_sel  = (i / 4) % 7;
      prev_sel = ((i - 1) / 4) % 7;
      chk("scan_csel", csel, exp_sel);
      chk("scan_wrap", wrap, (i % 28 == 0) ? 1 : 0);
      chk("scan_dout", dout, pat[prev_sel]);
    end

    // Pause at cur_sel=3, cnt=2
    repeat (14) tick();
    chk("pre_pause_csel", csel, 3);
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("pause_csel", csel, 3);
      chk("pause_wrap", wrap, 0);
    end
    hold = 1'b0;
    tick();
    chk("resume1_csel", csel, 3);
    tick();
    chk("resume2_csel", csel, 4);

    // Mode beats hold
    hold   = 1'b1;
    mode   = 1'b0;
    sel_in = 3'd5;
    tick();
    chk("prio_csel", csel, 5);
    chk("prio_wrap", wrap, 0);
    tick();
    chk("man_hold_csel", csel, 5);
    hold = 1'b0;
    mode = 1'b1;
    tick();
    chk("restart_csel", csel, 0);
    repeat (3) tick();
    chk("restart_dwell", csel, 0);
    tick();
    chk("restart_adv", csel, 1);

    // Async reset mid-scan at cur_sel=5, cnt=3
    mode = 1'b0;
    tick();
    mode = 1'b1;
    tick();
    repeat (23) tick();
    chk("pre_arst_csel",  csel,  5);
    chk("pre_arst_valid", valid, 1);
    #3;
    resetn = 1'b0;
    #1;
    chk("arst_csel",  csel,  0);
    chk("arst_dout",  dout,  0);
    chk("arst_valid", valid, 0);
    chk("arst_wrap",  wrap,  0);
    chk("arst_d1_csel", d1_csel, 0);
    #2;
    resetn = 1'b1;

    // DWELL=1 instance: advance every edge, wrap every 7
    tick();
    chk("d1_start", d1_csel, 0);
    for (int i = 1; i <= 14; i++) begin
      tick();
      chk("d1_csel", d1_csel, i % 7);
      chk("d1_wrap", d1_wrap, (i % 7 == 0) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
